bit_pattern_generator: RTL and testbench

- Serial stimulus source for the bit-pattern detection path: accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clk, on serial line x.
- x drives the detector's serial input directly.
- Optional expected-detect flag gives a cycle-aligned golden reference for the detector output y.

---
 rtl/bit_pattern_pkg.sv | 14 +
 rtl/bit_pattern_generator_matcher.sv | 28 ++
 rtl/bit_pattern_generator.sv | 129 ++++++++++++
 tb/tb_bit_pattern_generator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_pattern_pkg.sv
// Shared types and default constants for the bit-pattern generator and detector benches.
package bit_pattern_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    localparam int         DEF_WIDTH   = 8;
    localparam int         DEF_PAT_LEN = 3;
    localparam logic [7:0] DEF_PATTERN = 8'b0000_0110;

endpackage

// File: rtl/bit_pattern_generator_matcher.sv
// Golden detect flag: history of x plus compare against PATTERN (oldest bit = MSB).
module pattern_matcher
    import bit_pattern_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic reset,
    input  logic x_i,
    output logic match_o
);

    logic [PAT_LEN-2:0] hist_q;
    logic [PAT_LEN-1:0] win;

    assign win     = {hist_q, x_i};
    assign match_o = (win == PATTERN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= win[PAT_LEN-2:0];
        end
    end

endmodule

// File: rtl/bit_pattern_generator.sv
// MSB-first serializer with valid/ready load and optional inter-word gap.
// Define EXPECT_FLAG_EN to add the exp_y golden detect flag.
module bit_pattern_generator
    import bit_pattern_pkg::*;
#(
    parameter int                 WIDTH      = DEF_WIDTH,
    parameter int                 GAP        = 0,
    parameter logic               IDLE_LEVEL = 1'b0,
    parameter int                 PAT_LEN    = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN    = PAT_LEN'(DEF_PATTERN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             busy,
    output logic             done
`ifdef EXPECT_FLAG_EN
    ,
    output logic             exp_y
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       gcnt_q, gcnt_d;
    logic             x_q, x_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             accept;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        gcnt_d     = gcnt_q;
        x_d        = x_q;
        done_d     = 1'b0;
        load_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                load_ready = 1'b1;
                x_d        = IDLE_LEVEL;
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    x_d     = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    done_d     = 1'b1;
                    x_d        = IDLE_LEVEL;
                    load_ready = (GAP == 0);
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gcnt_d  = 8'(GAP - 1);
                    end
                end
            end
            S_GAP: begin
                x_d = IDLE_LEVEL;
                if (gcnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        accept = load_valid & load_ready;
        // An accept overrides the idle/last-bit path so words can stream gaplessly.
        if (accept) begin
            x_d     = data_in[WIDTH-1];
            shreg_d = data_in << 1;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_SHIFT;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            x_q     <= IDLE_LEVEL;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            x_q     <= x_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef EXPECT_FLAG_EN
    pattern_matcher #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .x_i     (x_q),
        .match_o (exp_y)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^PATTERN;
`endif

endmodule

// File: tb/tb_bit_pattern_generator.sv
// Bench for bit_pattern_generator: GAP=0 and GAP=2 instances vs a cycle-offset model.
// Define EXPECT_FLAG_EN to also check exp_y.
module tb_bit_pattern_generator;

    localparam int   W    = 8;
    localparam int   PL   = 3;
    localparam int   PAT  = 3'b110;
    localparam logic IDLE = 1'b0;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       ready0, ready2, x0, x2, busy0, busy2, done0, done2;
    logic [1:0] oy;
    logic [1:0] ox, ob, orr, od;

    int npass = 0;
    int ntot  = 0;

    assign ox  = {x2, x0};
    assign ob  = {busy2, busy0};
    assign orr = {ready2, ready0};
    assign od  = {done2, done0};

    bit_pattern_generator #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(IDLE)) d0 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready0),
        .x          (x0),
        .busy       (busy0),
        .done       (done0)
`ifdef EXPECT_FLAG_EN
        ,
        .exp_y      (oy[0])
`endif
    );

    bit_pattern_generator #(.WIDTH(W), .GAP(2), .IDLE_LEVEL(IDLE)) d2 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready2),
        .x          (x2),
        .busy       (busy2),
        .done       (done2)
`ifdef EXPECT_FLAG_EN
        ,
        .exp_y      (oy[1])
`endif
    );

`ifndef EXPECT_FLAG_EN
    assign oy = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Model: each word is described only by its acceptance cycle and value.
    int         cyc = 0;
    int         ma[2];
    int         mp[2];
    bit         mhave[2];
    bit         mphave[2];
    logic [7:0] mw[2];
    int         mhist[2];

    initial begin
        int   k, g;
        logic ex, eb, er, ed;
        for (int i = 0; i < 2; i++) begin
            mhave[i] = 0; mphave[i] = 0; mhist[i] = 0;
            ma[i] = 0; mp[i] = 0; mw[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    mhave[i] = 0; mphave[i] = 0; mhist[i] = 0;
                    chk("rst_x", ox[i], IDLE);
                    chk("rst_busy", ob[i], 0);
                    chk("rst_done", od[i], 0);
                end else begin
                    g  = (i == 1) ? 2 : 0;
                    k  = cyc - ma[i];
                    ex = IDLE; eb = 0; er = 1;
                    if (mhave[i] && k >= 1 && k <= W) begin
                        ex = mw[i][W-k];
                        eb = 1;
                        er = (g == 0) && (k == W);
                    end else if (mhave[i] && k > W && k <= W + g) begin
                        eb = 1;
                        er = 0;
                    end
                    ed = (mhave[i] && cyc == ma[i] + W + 1) ||
                         (mphave[i] && cyc == mp[i] + W + 1);
                    chk("x", ox[i], ex);
                    chk("busy", ob[i], eb);
                    chk("load_ready", orr[i], er);
                    chk("done", od[i], ed);
`ifdef EXPECT_FLAG_EN
                    chk("exp_y", oy[i], ((((mhist[i] << 1) | int'(ex)) & 7) == PAT));
`endif
                    mhist[i] = ((mhist[i] << 1) | int'(ex)) & ((1 << (PL - 1)) - 1);
                    if (load_valid && er) begin
                        mp[i] = ma[i]; mphave[i] = mhave[i];
                        ma[i] = cyc; mhave[i] = 1; mw[i] = data_in;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = ready0 & ready2 & ~busy0 & ~busy2;
            tick();
        end
        chk("idle_wait", 32'(ok), 1);
    endtask

    initial begin
        logic [7:0]  w;
        logic [7:0]  w2;
        logic [15:0] s16;
        logic [8:1]  ey;
        reset = 1'b0; load_valid = 1'b0; data_in = 8'h00;
        repeat (3) tick();
        reset = 1'b1;
        wait_idle();

        // Single word D6
        data_in = 8'hD6; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            w[8-c] = x0; ey[c] = oy[0];
            chk("t1_busy", busy0, 1);
            tick();
        end
        @(negedge clk);
        chk("t1_done0", done0, 1);
        chk("t1_busy0_end", busy0, 0);
        chk("t1_done2", done2, 1);
        chk("t1_busy2_gap", busy2, 1);
        chk("t1_word", w, 8'hD6);
`ifdef EXPECT_FLAG_EN
        chk("t1_expy", ey, 8'b1000_0100);
`endif
        tick();
        wait_idle();

        // Back-to-back FF then 00 on the GAP=0 instance
        data_in = 8'hFF; load_valid = 1'b1;
        tick();
        data_in = 8'h00;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            s16[16-c] = x0;
            if (c == 8 || c == 16) chk("t2_ready", ready0, 1);
            if (c == 9) chk("t2_done9", done0, 1);
            tick();
            if (c == 8) load_valid = 1'b0;
        end
        @(negedge clk);
        chk("t2_done17", done0, 1);
        chk("t2_stream", s16, 16'hFF00);
        tick();
        wait_idle();

        // Gap of 2 on the GAP=2 instance
        data_in = 8'hA5; load_valid = 1'b1;
        tick();
        data_in = 8'h5A;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c <= 8) w[8-c] = x2;
            if (c >= 12) w2[19-c] = x2;
            if (c == 9) chk("t3_done", done2, 1);
            if (c == 9 || c == 10) begin
                chk("t3_gap_ready", ready2, 0);
                chk("t3_gap_x", x2, IDLE);
            end
            if (c == 11) chk("t3_idle_ready", ready2, 1);
            tick();
            if (c == 11) load_valid = 1'b0;
        end
        chk("t3_word1", w, 8'hA5);
        chk("t3_word2", w2, 8'h5A);
        wait_idle();

        // Reset during bit 4 of D6, then 81
        data_in = 8'hD6; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t4_x0", x0, IDLE);
        chk("t4_x2", x2, IDLE);
        chk("t4_busy", busy0, 0);
        chk("t4_done", done0, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t4_ready", ready0, 1);
        data_in = 8'h81; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            w[8-c] = x0;
            tick();
        end
        @(negedge clk);
        chk("t4_done", done0, 1);
        chk("t4_word", w, 8'h81);
        tick();
        wait_idle();

        // Load attempt mid-word is ignored
        for (int c = 0; c <= 8; c++) begin
            load_valid = (c == 0 || c == 3);
            data_in = (c == 3) ? 8'h3C : 8'hD6;
            @(negedge clk);
            if (c >= 1) w[8-c] = x0;
            if (c == 3) chk("t5_ready", ready0, 0);
            tick();
        end
        load_valid = 1'b0;
        chk("t5_word", w, 8'hD6);
        wait_idle();

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            load_valid = ($urandom_range(0, 2) != 0);
            data_in = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end
        load_valid = 1'b0;
        repeat (15) tick();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

endmodule
